// File: rtl/float_to_int.sv
// Converts one IEEE-754 single-precision operand to a signed 32-bit integer, truncating toward zero.
// Latency: output_z_stb rises 4 clk edges after the input handshake edge. One operation is in flight at a time.
// Backpressure: PUT_Z holds output_z until output_z_ack is seen. input_a_ack is only high in GET_A.
//
// Ports:
//   clk, rst               - system clock; asynchronous active-low reset
//   input_a / _stb / _ack  - float operand handshake (transfer when stb && ack at a rising edge)
//   output_z / _stb / _ack - integer result handshake (transfer when stb && ack at a rising edge)
//   Out-of-range values, Inf and NaN return the saturation marker 32'h80000000.
module float_to_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    CONVERT,
    PUT_Z
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        a_reg;
  logic               sign_r;
  logic [7:0]         exp_r;
  logic signed [9:0]  exp_unb;   // unbiased exponent
  logic [23:0]        mant_r;    // significand with the hidden 1 restored
  logic               spec_zero;
  logic               spec_sat;
  logic [31:0]        z_res;

  logic [31:0] m_ext;
  logic [9:0]  shl_amt;
  logic [9:0]  shr_amt;
  logic [31:0] mag;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GET_A;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (input_a_ack && input_a_stb) state_nxt = UNPACK;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = CONVERT;
      CONVERT: state_nxt = PUT_Z;
      PUT_Z:   if (output_z_stb && output_z_ack) state_nxt = GET_A;
      default: state_nxt = GET_A;
    endcase
  end

  // Magnitude alignment.
  // In the normal range (0 <= e <= 30) the left shift is at most 7 bits,
  // so the 24-bit significand always fits in 31 bits.
  // Outside that range the result is replaced by the special-case value.
  assign m_ext = {8'b0, mant_r};

  always_comb begin
    shl_amt = exp_unb - 10'sd23;
    shr_amt = 10'sd23 - exp_unb;
    if (exp_unb >= 10'sd23) begin
      mag = m_ext << shl_amt;
    end else begin
      mag = m_ext >> shr_amt;
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'h0;
      a_reg        <= 32'h0;
      sign_r       <= 1'b0;
      exp_r        <= 8'h0;
      exp_unb      <= 10'sd0;
      mant_r       <= 24'h0;
      spec_zero    <= 1'b0;
      spec_sat     <= 1'b0;
      z_res        <= 32'h0;
    end else begin
      case (state)
        GET_A: begin
          // ack comes up one edge after reset, then stays up until a transfer.
          if (input_a_ack && input_a_stb) begin
            a_reg       <= input_a;
            input_a_ack <= 1'b0;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        UNPACK: begin
          sign_r  <= a_reg[31];
          exp_r   <= a_reg[30:23];
          exp_unb <= $signed({2'b00, a_reg[30:23]}) - 10'sd127;
          mant_r  <= {1'b1, a_reg[22:0]};
        end
        SPECIAL: begin
          spec_zero <= (exp_r == 8'd0) || (exp_unb < 10'sd0);
          spec_sat  <= (exp_r != 8'd0) && ((exp_r == 8'hFF) || (exp_unb > 10'sd30));
        end
        CONVERT: begin
          if (spec_zero) begin
            z_res <= 32'h0;
          end else if (spec_sat) begin
            z_res <= 32'h8000_0000;
          end else if (sign_r) begin
            z_res <= -mag;
          end else begin
            z_res <= mag;
          end
        end
        PUT_Z: begin
          // The result is loaded once, when stb rises.
          // It then holds until the downstream handshake completes.
          if (!output_z_stb) begin
            output_z_stb <= 1'b1;
            output_z     <= z_res;
          end else if (output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack  <= 1'b1;
          end
        end
        default: begin
          input_a_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int.
// A driver pushes each expected result when its input handshake is committed.
// A monitor pops and compares the entry when output_z_stb rises.
module tb_float_to_int;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_cycles = 0;

  logic [31:0] exp_q[$];
  int          hs_q[$];

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Directed vectors: operand and hand-computed integer result
  localparam int NV = 18;
  logic [31:0] va [NV] = '{
    32'h3F800000, 32'hC0200000, 32'h47F12000, 32'h2D764A65,
    32'h3F000000, 32'h80000000, 32'h4F000000, 32'hCF000000,
    32'h7F800000, 32'h7FC00000, 32'h4EFFFFFF, 32'hCEFFFFFF,
    32'h42C80000, 32'hBF800000, 32'h4B000000, 32'hBF000000,
    32'hFF800000, 32'h3FC00000};
  logic [31:0] vz [NV] = '{
    32'h00000001, 32'hFFFFFFFE, 32'h0001E240, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000,
    32'h80000000, 32'h80000000, 32'h7FFFFF80, 32'h80000080,
    32'h00000064, 32'hFFFFFFFF, 32'h00800000, 32'h00000000,
    32'h80000000, 32'h00000001};

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Called at a negedge. Holds stb until ack is seen high.
  // The following posedge is then the handshake edge.
  task automatic send(input logic [31:0] a, input logic [31:0] z);
    int n;
    n = 0;
    input_a = a;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!input_a_ack) begin
      chk(input_a_ack, "send_timeout", {31'b0, input_a_ack}, 32'h1);
      input_a_stb = 1'b0;
    end else begin
      exp_q.push_back(z);
      hs_q.push_back(cyc + 1);
      @(negedge clk);
      input_a_stb = 1'b0;
      input_a = 32'hDEADBEEF;  // must not disturb the captured operand
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || output_z_stb) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || output_z_stb) begin
      chk(1'b0, "drain_timeout", exp_q.size(), 32'h0);
    end
  endtask

  // Downstream acceptor.
  // While stb is low it drives random ack, which the DUT must ignore.
  // Once stb is high it stalls for hold_cycles observations, then accepts.
  initial begin
    int stall;
    stall = 0;
    output_z_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (output_z_stb) begin
        if (stall < hold_cycles) begin
          output_z_ack = 1'b0;
          stall++;
        end else begin
          output_z_ack = 1'b1;
        end
      end else begin
        stall = 0;
        output_z_ack = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor
  initial begin
    logic        prev_stb;
    logic [31:0] prev_z;
    logic [31:0] e;
    int          h;
    prev_stb = 1'b0;
    prev_z = 32'h0;
    forever begin
      @(negedge clk);
      if (output_z_stb && !prev_stb) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_stb", output_z, 32'h0);
        end else begin
          e = exp_q.pop_front();
          h = hs_q.pop_front();
          chk(output_z === e, "result", output_z, e);
          chk(cyc - h == 4, "latency", cyc - h, 32'd4);
        end
        chk(input_a_ack === 1'b0, "in_ack_low_in_put_z", {31'b0, input_a_ack}, 32'h0);
      end else if (output_z_stb && prev_stb) begin
        chk(output_z === prev_z, "z_stable", output_z, prev_z);
        chk(input_a_ack === 1'b0, "in_ack_low_while_stall", {31'b0, input_a_ack}, 32'h0);
      end else if (!output_z_stb && prev_stb) begin
        chk(input_a_ack === 1'b1, "in_ack_after_out", {31'b0, input_a_ack}, 32'h1);
      end
      prev_stb = output_z_stb;
      prev_z = output_z;
    end
  end

  // Stimulus
  initial begin
    rst = 1'b0;
    input_a = 32'h0;
    input_a_stb = 1'b0;
    repeat (3) @(negedge clk);
    chk(input_a_ack === 1'b0, "rst_in_ack", {31'b0, input_a_ack}, 32'h0);
    chk(output_z_stb === 1'b0, "rst_out_stb", {31'b0, output_z_stb}, 32'h0);
    chk(output_z === 32'h0, "rst_out_z", output_z, 32'h0);
    rst = 1'b1;
    #1;
    chk(input_a_ack === 1'b0, "in_ack_before_first_edge", {31'b0, input_a_ack}, 32'h0);
    @(negedge clk);
    chk(input_a_ack === 1'b1, "in_ack_first_edge", {31'b0, input_a_ack}, 32'h1);

    for (int i = 0; i < NV; i++) send(va[i], vz[i]);
    drain();

    // Long stall while the result is presented
    hold_cycles = 20;
    send(32'h47F12000, 32'h0001E240);
    drain();
    hold_cycles = 0;

    // Abort during CONVERT. pi would have produced 3.
    send(32'h40490FDB, 32'h00000003);
    @(negedge clk);  // SPECIAL
    @(negedge clk);  // CONVERT
    rst = 1'b0;
    #1;
    chk(input_a_ack === 1'b0, "abort_in_ack", {31'b0, input_a_ack}, 32'h0);
    chk(output_z_stb === 1'b0, "abort_out_stb", {31'b0, output_z_stb}, 32'h0);
    chk(output_z === 32'h0, "abort_out_z", output_z, 32'h0);
    exp_q.delete();
    hs_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk(input_a_ack === 1'b0, "abort_ack_before_edge", {31'b0, input_a_ack}, 32'h0);
    @(negedge clk);
    chk(input_a_ack === 1'b1, "abort_ack_after_edge", {31'b0, input_a_ack}, 32'h1);
    send(32'h41200000, 32'h0000000A);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
